// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequences an AES state one column per cycle through a shared MixColumns unit
module mix_columns_seq #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic [31:0]  mc_col_out,
  input  logic [31:0]  mc_col_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   col_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] cap;
  logic         eff_bypass;

  assign eff_bypass = BYPASS_EN & in_bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = eff_bypass ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (col_idx == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out_state is only flagged valid in DONE, so partial writes during RUN are never exposed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap       <= '0;
      out_state <= '0;
      col_idx   <= 2'd0;
    end else begin
      if (state == IDLE && in_valid) begin
        cap     <= in_state;
        col_idx <= 2'd0;
        if (eff_bypass) out_state <= in_state;
      end else if (state == RUN) begin
        for (int c = 0; c < 4; c++) begin
          if (col_idx == 2'(c)) out_state[127-32*c -: 32] <= mc_col_in;
        end
        col_idx <= col_idx + 2'd1;
      end
    end
  end

  always_comb begin
    mc_col_out = 32'h0;
    if (state == RUN) begin
      case (col_idx)
        2'd0:    mc_col_out = cap[127:96];
        2'd1:    mc_col_out = cap[95:64];
        2'd2:    mc_col_out = cap[63:32];
        default: mc_col_out = cap[31:0];
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - directed-vector bench for mix_columns_seq
module tb_mix_columns_seq;

  logic         clk, rst_n;
  logic         in_valid, in_bypass, out_ready;
  logic [127:0] in_state;
  logic         in_ready, out_valid, busy;
  logic [31:0]  mc_col_out, mc_col_in;
  logic [127:0] out_state;
  logic [1:0]   col_idx;

  logic         in_valid_b, out_ready_b;
  logic         in_ready_b, out_valid_b, busy_b;
  logic [31:0]  mc_col_out_b, mc_col_in_b;
  logic [127:0] out_state_b;
  logic [1:0]   col_idx_b;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  assign mc_col_in   = mixcol(mc_col_out);
  assign mc_col_in_b = mixcol(mc_col_out_b);

  mix_columns_seq #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_bypass(in_bypass), .mc_col_out(mc_col_out),
    .mc_col_in(mc_col_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy), .col_idx(col_idx)
  );

  mix_columns_seq #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_state(in_state), .in_bypass(in_bypass), .mc_col_out(mc_col_out_b),
    .mc_col_in(mc_col_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_state(out_state_b), .busy(busy_b), .col_idx(col_idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},   128'(in_ready),   128'd1);
    check({tag, " out_valid"},  128'(out_valid),  128'd0);
    check({tag, " busy"},       128'(busy),       128'd0);
    check({tag, " col_idx"},    128'(col_idx),    128'd0);
    check({tag, " out_state"},  out_state,        128'h0);
    check({tag, " mc_col_out"}, 128'(mc_col_out), 128'h0);
  endtask

  // one normal transaction with out_ready high; reports observed latency in negedges
  task automatic run_full(input string tag, input logic [127:0] st, input logic [127:0] exp);
    int cyc;
    check({tag, " in_ready"}, 128'(in_ready), 128'd1);
    in_state = st; in_bypass = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'd5);
    check({tag, " out_state"}, out_state, exp);
    @(negedge clk);
  endtask

  localparam logic [127:0] V0 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] E0 = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] E1 = 128'h22770055_66334411_aaff88dd_eebbcc99;
  localparam logic [127:0] V2 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E2 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V3 = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] E3 = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

  initial begin
    logic [127:0] v0_reg;
    logic [127:0] st [3];
    logic [127:0] ex [3];
    int ii, oi;
    bit seen;

    rst_n = 1'b0; in_valid = 1'b0; in_bypass = 1'b0; in_state = '0; out_ready = 1'b0;
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // normal path from the first edge after reset, with backpressure in DONE
    v0_reg = V0;
    in_state = V0; in_bypass = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_state = {4{32'hdeadbeef}}; in_bypass = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("run col_idx %0d", k), 128'(col_idx), 128'(k));
      check($sformatf("run mc_col_out %0d", k), 128'(mc_col_out), 128'(v0_reg[127-32*k -: 32]));
      check($sformatf("run busy %0d", k), 128'(busy), 128'd1);
      check($sformatf("run out_valid %0d", k), 128'(out_valid), 128'd0);
      check($sformatf("run in_ready %0d", k), 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    check("done busy", 128'(busy), 128'd0);
    check("done col_idx", 128'(col_idx), 128'd0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      check($sformatf("bp out_valid %0d", i), 128'(out_valid), 128'd1);
      check($sformatf("bp out_state %0d", i), out_state, E0);
      check($sformatf("bp in_ready %0d", i), 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", 128'(out_valid), 128'd0);
    check("bp release in_ready", 128'(in_ready), 128'd1);

    // bypass with BYPASS_EN=1
    out_ready = 1'b0;
    check("byp idle mc_col_out", 128'(mc_col_out), 128'h0);
    in_state = V1; in_bypass = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("byp out_valid", 128'(out_valid), 128'd1);
    check("byp out_state", out_state, V1);
    check("byp mc_col_out", 128'(mc_col_out), 128'h0);
    check("byp busy", 128'(busy), 128'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("byp in_ready", 128'(in_ready), 128'd1);

    // same stimulus on the BYPASS_EN=0 instance takes the normal path
    out_ready_b = 1'b0;
    in_state = V1; in_bypass = 1'b1; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("nobyp busy %0d", k), 128'(busy_b), 128'd1);
      check($sformatf("nobyp out_valid %0d", k), 128'(out_valid_b), 128'd0);
      @(negedge clk);
    end
    check("nobyp out_valid", 128'(out_valid_b), 128'd1);
    check("nobyp out_state", out_state_b, E1);
    out_ready_b = 1'b1;
    @(negedge clk);
    check("nobyp in_ready", 128'(in_ready_b), 128'd1);

    // asynchronous reset while column 2 is on the bus
    in_bypass = 1'b0; in_state = V0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid col_idx", 128'(col_idx), 128'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("no out_valid after discard", 128'(seen), 128'd0);
    run_full("post-reset", V2, E2);

    // back-to-back with in_valid held high
    st[0] = V0; st[1] = V3; st[2] = V2;
    ex[0] = E0; ex[1] = E3; ex[2] = E2;
    ii = 0; oi = 0;
    for (int cyc = 0; cyc < 80 && oi < 3; cyc++) begin
      if (out_valid) begin
        if (oi < 3) check($sformatf("b2b out_state %0d", oi), out_state, ex[oi]);
        oi++;
      end
      if (in_ready && ii < 3) begin
        in_state = st[ii]; in_valid = 1'b1; ii++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end else begin
        in_state = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b results", 128'(oi), 128'd3);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("b2b no extra result", 128'(seen), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1: 1 honours in_bypass; 0 ignores in_bypass and treats it as 0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  in_state and in_bypass are valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a state.
REQ-006 SHALL have port in_state  input  128  AES state; column c = bits [127-32c -: 32], c = 0..3.
REQ-007 SHALL have port in_bypass  input  1  skip MixColumns (final round), sampled with in_state.
REQ-008 SHALL have port mc_col_out  output  32  column driven to the shared 32-bit MixColumns unit.
REQ-009 SHALL have port mc_col_in  input  32  combinational result returned by the shared unit for mc_col_out.
REQ-010 SHALL have port out_valid  output  1  out_state holds a finished state.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_state.
REQ-012 SHALL have port out_state  output  128  result state, same column layout as in_state.
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port col_idx  output  2  column currently on mc_col_out.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and busy SHALL be 1 only in RUN.
REQ-017 An input handshake (in_valid & in_ready) at an edge SHALL capture in_state into an internal register and set col_idx to 0.
REQ-018 On that handshake, the FSM SHALL go to RUN if the effective bypass is 0.
REQ-019 On that handshake, if the effective bypass is 1, out_state SHALL load in_state unchanged and the FSM SHALL go to DONE.
REQ-020 In RUN, mc_col_out SHALL combinationally equal captured column col_idx.
REQ-021 In IDLE and DONE, mc_col_out SHALL be 32'h0.
REQ-022 At each RUN edge, mc_col_in SHALL be written into out_state column col_idx.
REQ-023 At each RUN edge, col_idx SHALL increment modulo 4.
REQ-024 After column 3 is written, the FSM SHALL go to DONE and col_idx SHALL wrap to 0.
REQ-025 Latency SHALL be fixed: out_valid rises 4 cycles after the input-handshake edge (normal) or 1 cycle after it (bypass).
REQ-026 out_valid SHALL be 1 exactly in DONE.
REQ-027 out_state SHALL be held stable from when out_valid rises until the output handshake.
REQ-028 Partially written columns of out_state SHALL never be flagged valid.
REQ-029 An output handshake (out_valid & out_ready) SHALL return the FSM to IDLE.
REQ-030 A new input SHALL be accepted no earlier than the edge after the return to IDLE, so throughput is at most 1 state per 6 cycles (normal).
REQ-031 in_valid in RUN or DONE SHALL be ignored and the input SHALL not be captured.
REQ-032 The block SHALL hold indefinitely in DONE while out_ready = 0.
REQ-033 Changes on in_state or in_bypass after capture SHALL not affect the result in flight.
REQ-034 The block SHALL perform no GF arithmetic itself; all column transformation SHALL come through mc_col_in.

Reset
REQ-035 rst_n = 0 SHALL immediately force IDLE: in_ready = 1, out_valid = 0, busy = 0, col_idx = 0, out_state = 128'h0, captured register = 128'h0, mc_col_out = 32'h0.
REQ-036 A reset asserted in RUN or DONE SHALL discard the in-flight state.
REQ-037 No out_valid pulse SHALL appear after the discard.
REQ-038 The first input handshake SHALL be possible at the first rising edge with rst_n = 1.

Verification
REQ-039 Normal path, bench connects a reference MixColumns model to mc_col_out/mc_col_in: in_state = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, bypass 0 -> out_valid 4 cycles after handshake, out_state = 128'h046681e5_e0cb199a_48f8d37a_2806264c.
REQ-040 Column sequencing: during the same run, col_idx goes 0,1,2,3 and mc_col_out equals d4bf5d30, e0b452ae, b84111f1, 1e2798e5 on successive cycles; busy = 1 for exactly 4 cycles.
REQ-041 Bypass: in_state = 128'h00112233_44556677_8899aabb_ccddeeff, bypass 1 -> out_valid 1 cycle after handshake, out_state equals in_state, mc_col_out stays 0. With BYPASS_EN = 0, the same stimulus takes the 4-cycle normal path.
REQ-042 Backpressure: out_ready = 0 for 10 cycles in DONE -> out_valid and out_state are held, in_ready = 0, in_valid pulses are ignored. out_ready = 1 -> IDLE next cycle, in_ready = 1.
REQ-043 Reset mid-run: assert rst_n = 0 asynchronously while col_idx = 2 -> all outputs reach reset values without a clock edge. After release, a new state 128'hdb135345_... processes correctly (first column result 8e4da1bc).
REQ-044 Back-to-back: in_valid held high with 3 different states and out_ready = 1 -> each is accepted only in IDLE, results come out in order with correct values, and no state is dropped or duplicated.
